// File: rtl/vi_gap_sched.sv
// vi_gap_sched: 320 kHz bit-strobe generator with one suppressed "gap" pulse per group.
// Start and stop are sequenced on group boundaries. The group configuration is
// writable only while idle.
module vi_gap_sched #(
  parameter int DIV       = 125,
  parameter int DEF_SLOTS = 40,
  parameter int DEF_GAP   = 39
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iStart,
  input  logic       iStop,
  input  logic       iCfgValid,
  input  logic [6:0] iCfgSlots,
  input  logic [6:0] iCfgGap,
  output logic       oCfgReady,
  output logic       oCfgErr,
  output logic       o320,
  output logic       oVI,
  output logic       oGap,
  output logic       oGroupEnd,
  output logic       oBusy
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PH_LAST    = PW'(DIV - 1);
  localparam logic [6:0]    SLOTS_INIT = 7'(DEF_SLOTS);
  localparam logic [6:0]    GAP_INIT   = 7'(DEF_GAP);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase;
  logic [6:0]    slot;
  logic [6:0]    cfg_slots;
  logic [6:0]    cfg_gap;

  logic tick;      // half-period boundary on this edge
  logic fall;      // o320 falls on this edge
  logic last_slot; // current slot is the last of the group
  logic grp_end;   // falling edge that closes the group

  assign tick      = (phase == PH_LAST);
  assign fall      = tick && o320;
  assign last_slot = (slot == (cfg_slots - 7'd1));
  assign grp_end   = fall && last_slot;

  // State register for the run sequencer.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: start only from IDLE, stop only from RUN, drain to a group boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart)  state_nxt = RUN;
      RUN:     if (iStop)   state_nxt = DRAIN;
      DRAIN:   if (grp_end) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Strobe generation, slot counting, config register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      slot      <= '0;
      o320      <= 1'b0;
      oVI       <= 1'b0;
      oGap      <= 1'b0;
      oGroupEnd <= 1'b0;
      oCfgErr   <= 1'b0;
      oBusy     <= 1'b0;
      oCfgReady <= 1'b1;
      cfg_slots <= SLOTS_INIT;
      cfg_gap   <= GAP_INIT;
    end else begin
      oGroupEnd <= 1'b0;
      oCfgErr   <= 1'b0;
      oBusy     <= (state_nxt != IDLE);
      oCfgReady <= (state_nxt == IDLE);
      if (state == IDLE) begin
        // Idle also covers the cycle that enters RUN, so every run starts from phase 0.
        phase <= '0;
        slot  <= '0;
        o320  <= 1'b0;
        oVI   <= 1'b0;
        oGap  <= 1'b0;
        if (iCfgValid) begin
          if ((iCfgSlots >= 7'd2) && (iCfgGap < iCfgSlots)) begin
            cfg_slots <= iCfgSlots;
            cfg_gap   <= iCfgGap;
          end else begin
            oCfgErr <= 1'b1;
          end
        end
      end else if (tick) begin
        phase <= '0;
        if (o320) begin
          o320 <= 1'b0;
          oVI  <= 1'b0;
          oGap <= 1'b0;
          if (last_slot) begin
            slot      <= '0;
            oGroupEnd <= 1'b1;
          end else begin
            slot <= slot + 7'd1;
          end
        end else begin
          o320 <= 1'b1;
          oVI  <= (slot != cfg_gap);
          oGap <= (slot == cfg_gap);
        end
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

endmodule
